// File: rtl/fa_tester_pkg.sv
// fa_tester_pkg: shared types, widths and the full-adder reference for the pmod loopback tester
package fa_tester_pkg;
  localparam int VEC_W = 3;
  localparam int RES_W = 2;
  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, HOLD, DONE} state_t;
  // vec = {cin, b, a}; result = {carry, sum}
  function automatic logic [RES_W-1:0] fa_expected(input logic [VEC_W-1:0] vec);
    return {(vec[0] & vec[1]) | (vec[0] & vec[2]) | (vec[1] & vec[2]), ^vec};
  endfunction
endpackage

// File: rtl/fa_pmod_tester_sync_ff.sv
// sync_ff: multi-stage flop synchronizer for an asynchronous bus
//   clk, rst (async, active-high) ; d: async input ; q: synchronized output
module sync_ff #(
  parameter int W = 1,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s [D];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < D; i++) s[i] <= '0;
    end else begin
      s[0] <= d;
      for (int i = 1; i < D; i++) s[i] <= s[i-1];
    end
  assign q = s[D-1];
endmodule

// File: rtl/fa_pmod_tester.sv
// fa_pmod_tester: sweeps all 8 full-adder vectors over pmod and checks the looped-back sum/carry
//   clk, rst (async, active-high), start (pulse) ; pmod_out = {cin, b, a} ; res_in = {carry, sum}
//   busy, done, pass, err_count, fail_vec ; led = {sync res_in, done&~pass, done&pass, busy}
module fa_pmod_tester
  import fa_tester_pkg::*;
#(
  parameter int STEP_CYCLES   = 12000000,
  parameter int SETTLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [VEC_W-1:0] pmod_out,
  input  logic [RES_W-1:0] res_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       err_count,
  output logic [VEC_W-1:0] fail_vec,
  output logic [4:0]       led
);
  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(SETTLE_CYCLES + SYNC_STAGES - 1);
  localparam logic [CW-1:0] LAST      = CW'(STEP_CYCLES - 1);
  if (STEP_CYCLES < SETTLE_CYCLES + SYNC_STAGES + 2) begin : g_bad_step
    $error("STEP_CYCLES must be >= SETTLE_CYCLES + SYNC_STAGES + 2");
  end
  state_t           state, nxt;
  logic [VEC_W-1:0] vec;
  logic [CW-1:0]    cnt;
  logic [RES_W-1:0] res_s;
  logic             go, last, mis;
  sync_ff #(.W(RES_W), .D(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(res_in), .q(res_s));
  assign go   = start && (state == IDLE || state == DONE);
  assign last = state == HOLD && cnt == LAST;
  assign mis  = res_s != fa_expected(vec);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = start ? DRIVE : state;
      DRIVE:      nxt = cnt == SAMPLE_AT ? SAMPLE : DRIVE;
      SAMPLE:     nxt = HOLD;
      HOLD:       nxt = !last ? HOLD : &vec ? DONE : DRIVE;
      default:    nxt = IDLE;
    endcase
  end
  // cnt runs across DRIVE/SAMPLE/HOLD so each vector is held exactly STEP_CYCLES
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vec       <= '0;
      cnt       <= '0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      cnt       <= (state == IDLE || state == DONE || last) ? '0 : cnt + 1'b1;
      vec       <= go ? '0 : (last && !(&vec)) ? vec + 1'b1 : vec;
      err_count <= go ? '0 : (state == SAMPLE && mis) ? err_count + 4'd1 : err_count;
      fail_vec  <= go ? '0 : (state == SAMPLE && mis && err_count == '0) ? vec : fail_vec;
    end
  always_comb begin
    busy     = state == DRIVE || state == SAMPLE || state == HOLD;
    done     = state == DONE;
    pass     = done && err_count == '0;
    pmod_out = busy ? vec : '0;
    led      = {res_s, done && !pass, pass, busy};
  end
endmodule

// File: tb/tb_fa_pmod_tester.sv
// tb_fa_pmod_tester: randomized loopback bench with a behavioural full-adder model
module tb_fa_pmod_tester;
  localparam int STEP = 32;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] pmod_out, pmod8, fail_vec, fail8;
  logic [1:0] res_in, res8;
  logic       busy, done, pass, busy8, done8, pass8;
  logic [3:0] err_count, err8;
  logic [4:0] led, led8;
  int         vectors = 0, miscompares = 0, mode = 0;
  logic [1:0] flip [8];
  logic [1:0] dly [5];
  logic [1:0] dly8 [5];

  fa_pmod_tester #(.STEP_CYCLES(STEP), .SETTLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .pmod_out(pmod_out), .res_in(res_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec), .led(led));
  fa_pmod_tester #(.STEP_CYCLES(STEP), .SETTLE_CYCLES(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .start(start), .pmod_out(pmod8), .res_in(res8),
    .busy(busy8), .done(done8), .pass(pass8), .err_count(err8), .fail_vec(fail8), .led(led8));

  always #5 clk = ~clk;

  // adding the three input bits gives {carry, sum} directly
  function automatic logic [1:0] fa_ref(input logic [2:0] v);
    int n;
    n = int'(v[0]) + int'(v[1]) + int'(v[2]);
    return 2'(n);
  endfunction

  // value the loopback presents when vector v is sampled under the current fault mode
  function automatic logic [1:0] seen(input int v);
    logic [2:0] p;
    p = (v == 0) ? 3'd0 : 3'(v - 1);
    return mode == 1 ? (fa_ref(3'(v)) & 2'b01) :
           mode == 2 ? fa_ref(p) :
           mode == 3 ? (fa_ref(3'(v)) ^ flip[v]) : fa_ref(3'(v));
  endfunction

  always @(posedge clk) begin
    dly[0]  <= fa_ref(pmod_out);
    dly8[0] <= fa_ref(pmod8);
    for (int i = 1; i < 5; i++) begin
      dly[i]  <= dly[i-1];
      dly8[i] <= dly8[i-1];
    end
  end

  always_comb begin
    res8   = dly8[4];
    res_in = mode == 1 ? (fa_ref(pmod_out) & 2'b01) :
             mode == 2 ? dly[4] :
             mode == 3 ? (fa_ref(pmod_out) ^ flip[pmod_out]) : fa_ref(pmod_out);
  end

  task automatic run_sweep(input string name, input int poke, input int hold);
    int e = 0, fv = 0;
    logic [4:0] exp_t, got_t;
    logic [12:0] exp_r, got_r;
    for (int v = 0; v < 8; v++)
      if (seen(v) !== fa_ref(3'(v))) begin
        if (e == 0) fv = v;
        e++;
      end
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 8 * STEP; j++) begin
      @(negedge clk);
      exp_t = {(j < 8 * STEP) ? 3'(j / STEP) : 3'd0, j < 8 * STEP, j == 8 * STEP};
      got_t = {pmod_out, busy, done};
      vectors++;
      if (got_t !== exp_t) begin
        miscompares++;
        $display("FAIL %s cycle %0d {pmod,busy,done}: got %b want %b", name, j, got_t, exp_t);
      end
      if (j == 0) begin
        vectors++;
        if ({err_count, fail_vec} !== 7'd0) begin
          miscompares++;
          $display("FAIL %s start-clear {err,fail}: got %b want 0", name, {err_count, fail_vec});
        end
      end
      start = (j + 1 < hold) || (j == poke);
    end
    start = 1'b0;
    exp_r = {e == 0, 4'(e), 3'(fv), 2'b00, e != 0, e == 0, 1'b0};
    got_r = {pass, err_count, fail_vec, 2'b00, led[2:0]};
    vectors++;
    if (got_r !== exp_r) begin
      miscompares++;
      $display("FAIL %s result {pass,err,fail,00,led}: got %b want %b", name, got_r, exp_r);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({pmod_out, busy, done, pass, err_count, fail_vec, led} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset outputs: got %b want 0", {pmod_out, busy, done, pass, err_count, fail_vec, led});
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    vectors++;
    if ({pmod_out, busy, done, pass, err_count, fail_vec, led} !== 18'd0) begin
      miscompares++;
      $display("FAIL idle outputs: got %b want 0", {pmod_out, busy, done, pass, err_count, fail_vec, led});
    end
  endtask

  task automatic test_ideal();
    mode = 0;
    run_sweep("ideal", -1, 1);
  endtask

  task automatic test_back_to_back();
    mode = 1;
    run_sweep("stuck_carry", -1, 1);
    mode = 0;
    run_sweep("restart_from_done", -1, 1);
  endtask

  task automatic test_slow();
    mode = 2;
    pulse_reset();
    run_sweep("slow_settle4", -1, 1);
    vectors++;
    if ({done8, pass8, err8, fail8} !== {1'b1, 1'b1, 4'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL slow_settle8 {done,pass,err,fail}: got %b want 11_0000_000", {done8, pass8, err8, fail8});
    end
    mode = 0;
  endtask

  task automatic test_abort_reset();
    pulse_reset();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4 * STEP + 9) @(negedge clk);
    vectors++;
    if (pmod_out !== 3'd4) begin
      miscompares++;
      $display("FAIL abort pre-reset pmod: got %0d want 4", pmod_out);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({pmod_out, busy, done, pass, err_count, fail_vec, led} !== 18'd0) begin
      miscompares++;
      $display("FAIL abort async-reset outputs: got %b want 0", {pmod_out, busy, done, pass, err_count, fail_vec, led});
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    run_sweep("after_abort", -1, 1);
  endtask

  task automatic test_start_while_busy();
    run_sweep("start_at_100", 100, 1);
    run_sweep("start_held_3", -1, 3);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) flip[i] = ($urandom_range(0, 2) == 0) ? 2'(($urandom_range(1, 3))) : 2'b00;
      mode = 3;
      repeat ($urandom_range(3, 10)) @(negedge clk);
      run_sweep($sformatf("random_%0d", r), -1, 1);
      repeat (4) @(negedge clk);
      vectors++;
      if ({done, led[4:3]} !== {1'b1, flip[0]}) begin
        miscompares++;
        $display("FAIL random_%0d idle {done,led[4:3]}: got %b want %b", r, {done, led[4:3]}, {1'b1, flip[0]});
      end
    end
    mode = 0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) flip[i] = 2'b00;
    test_reset();
    test_ideal();
    test_back_to_back();
    test_slow();
    test_abort_reset();
    test_start_while_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fa_pmod_tester.md
Name: fa_pmod_tester

Overview:
- Loopback stimulus/checker for the pmod-connected full-adder logic: the driving-and-checking end of the pmod-in / led-out interface.
- Steps through all 8 (a, b, cin) vectors on pmod output pins and samples the returned 2-bit sum/carry after a settle delay.
- Compares each sample against the full-adder truth table and reports pass/fail, error count and first failing vector on the iCEstick LEDs.
- Sits at top level between the pmod header and LED pins, on the 12 MHz board clock.

Parameters:
- STEP_CYCLES, 12000000, clock cycles each vector is held, from drive to next drive; 1 s at 12 MHz.
- SETTLE_CYCLES, 16, cycles after driving a vector before the result is sampled.
- SYNC_STAGES, 2, flip-flop depth of the res_in synchronizer.

Ports:
- clk  in  1  board clock, 12 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a sweep when the FSM is idle or done.
- pmod_out  out  3  stimulus: bit0 = a, bit1 = b, bit2 = cin.
- res_in  in  2  returned result, asynchronous to clk: bit0 = sum, bit1 = carry.
- busy  out  1  high while a sweep is running.
- done  out  1  high from sweep end until the next start or reset.
- pass  out  1  valid when done; 1 = all 8 vectors matched.
- err_count  out  4  number of mismatching vectors, 0..8.
- fail_vec  out  3  first mismatching vector; 0 if none.
- led  out  5  led[0] = busy, led[1] = done&pass, led[2] = done&~pass, led[4:3] = synchronized res_in.

Behaviour:
Reset (asynchronous, any state):
- All outputs are 0; FSM enters IDLE.
- Counters and synchronizer flops clear.
- Reset mid-sweep aborts the sweep; no partial result is retained.

Synchronizer:
- res_in passes through SYNC_STAGES flops before any use.
- The effective sample point is SETTLE_CYCLES + SYNC_STAGES cycles after pmod_out changes.

FSM states:
- IDLE: pmod_out = 0. start → DRIVE with vec = 0, err_count = 0, fail_vec = 0, done = 0. busy goes high the cycle after start is sampled.
- DRIVE: pmod_out = vec. Cycle counter counts from 0; at count = SETTLE_CYCLES + SYNC_STAGES − 1 → SAMPLE.
- SAMPLE (1 cycle):
  - Expected sum = a^b^cin; expected carry = ab | acin | bcin.
  - On mismatch, err_count increments. If this is the first error (err_count was 0), fail_vec = vec.
  - → HOLD.
- HOLD: pmod_out holds vec until the counter reaches STEP_CYCLES − 1. Then:
  - If vec = 7 → DONE (no wrap to 0).
  - Otherwise vec increments, counter clears → DRIVE.
- DONE: busy = 0, done = 1, pass = (err_count == 0). pmod_out returns to 0. start → DRIVE exactly as from IDLE, and clears done/pass/err_count/fail_vec.

Boundary rules:
- start while busy is ignored.
- start coincident with the final HOLD→DONE transition: the FSM takes DONE; the pulse is ignored.
- STEP_CYCLES must be ≥ SETTLE_CYCLES + SYNC_STAGES + 2. Violating this is an elaboration error via a generate-time check.
- The cycle counter is sized by $clog2(STEP_CYCLES) and never wraps inside a step.
- err_count maxes at 8 and cannot overflow 4 bits.
- Sweep latency from start to done = 8 × STEP_CYCLES + 1 cycles.

Decomposition:
- Package fa_tester_pkg holds:
  - state enum (IDLE, DRIVE, SAMPLE, HOLD, DONE);
  - VEC_W = 3 and RES_W = 2;
  - function fa_expected(vec) returning {carry, sum}.
- One sub-module, sync_ff (parameterised width and depth, async active-high reset), is used for res_in.
- Everything else lives in fa_pmod_tester.

Test Plan:
All scenarios use STEP_CYCLES = 32, SETTLE_CYCLES = 4, SYNC_STAGES = 2.
- Ideal loopback (bench model drives res_in = fa(pmod_out) combinationally), pulse start → pmod_out steps 0..7, each held 32 cycles; done at cycle 257; pass = 1, err_count = 0, fail_vec = 0, led[1] = 1.
- Stuck-at-0 carry (res_in[1] = 0) → vectors 3, 5, 6, 7 fail; err_count = 4, fail_vec = 3, pass = 0, led[2] = 1.
- Slow DUT (res_in updates 5 cycles after pmod_out) → sampled value is stale; the check fails on each vector where the result changes. Same DUT with SETTLE_CYCLES = 8 → pass = 1.
- rst asserted asynchronously mid-step while vec = 4 → all outputs 0 immediately, FSM in IDLE. Subsequent start yields a full clean sweep from vec 0.
- start pulsed at cycle 100 of a sweep → ignored, sweep timing unchanged. start pulsed in DONE → err_count/done clear and a new sweep begins the next cycle.
- start held high for 3 cycles from IDLE → exactly one sweep. The later start-high cycles (sampled while busy) do not restart it.
